// File: rtl/rle_pkg.sv
// rle_pkg: widths, run/best records and analyzer FSM states shared by the
// run-length analyzer and its best-run tracker.
package rle_pkg;

    localparam int X_W   = 11;
    localparam int LEN_W = 10;
    localparam int ROW_W = 10;

    typedef struct packed {
        logic [X_W-1:0]   start;
        logic [LEN_W-1:0] len;
    } run_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        run_t             run;
    } best_t;

    typedef enum logic [1:0] {
        ST_ACCUM     = 2'd0,
        ST_LINE_OUT  = 2'd1,
        ST_FRAME_OUT = 2'd2
    } state_t;

    // Centre of a run: start plus half its length (rounded down).
    function automatic logic [X_W-1:0] run_center(input run_t r);
        return r.start + X_W'(r.len >> 1);
    endfunction

endpackage

// File: rtl/rle_best_tracker.sv
// rle_best_tracker: holds the longest run seen so far. A candidate replaces
// the held value only when strictly longer, so the earliest of equal runs
// is kept. merged_o is the value including this cycle's candidate, so a
// consumer can capture the final result in the same cycle it clears.
module rle_best_tracker
    import rle_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clr_i,
    input  logic  upd_i,
    input  best_t cand_i,
    output best_t merged_o
);

    best_t best_q;
    best_t best_d;

    // Strictly-greater merge of the candidate, then optional clear.
    always_comb begin
        merged_o = best_q;
        if (upd_i && (cand_i.run.len > best_q.run.len)) begin
            merged_o = cand_i;
        end
        best_d = clr_i ? '0 : merged_o;
    end

    // Best-run register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

endmodule

// File: rtl/rle_run_analyzer.sv
// rle_run_analyzer: consumes one RLE run per cycle, reports the longest
// foreground run of every line and (optionally) the widest line of a frame.
// Optional frame-best feature: define RLE_ANALYZER_FRAME_EN.
module rle_run_analyzer
    import rle_pkg::*;
#(
    parameter logic [X_W-1:0]   IMAGE_W = 11'd640,
    parameter logic [ROW_W-1:0] IMAGE_H = 10'd480,
    parameter logic [LEN_W-1:0] MIN_RUN = 10'd4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             run_valid,
    input  logic             run_value,
    input  logic [LEN_W-1:0] run_len,
    input  logic             line_end,
    input  logic             frame_end,
    output logic             line_valid,
    output logic [X_W-1:0]   line_start,
    output logic [LEN_W-1:0] line_len,
    output logic [X_W-1:0]   line_center,
    output logic             frame_valid,
    output logic [ROW_W-1:0] frame_row,
    output logic [X_W-1:0]   frame_start,
    output logic [LEN_W-1:0] frame_len,
    output logic             geom_err
);

    state_t           state_q, state_d;
    logic             both_q, both_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             geom_err_q, geom_err_d;
    run_t             line_q, line_d;

    logic             line_done;
    logic             frame_done;
    logic             overflow;
    logic             row_full;
    logic             cand_ok;
    logic [X_W:0]     x_sum;
    logic [X_W-1:0]   x_room;
    logic [LEN_W-1:0] len_eff;
    best_t            line_cand;
    best_t            line_merged;

    // Run geometry: clamp at the right image edge and qualify candidates.
    always_comb begin
        line_done  = run_valid & line_end;
        frame_done = frame_end;
        x_sum      = {1'b0, x_q} + {{(X_W + 1 - LEN_W){1'b0}}, run_len};
        x_room     = IMAGE_W - x_q;
        overflow   = run_valid && (x_sum > {1'b0, IMAGE_W});
        len_eff    = '0;
        if (run_valid) begin
            len_eff = overflow ? LEN_W'(x_room) : run_len;
        end
        cand_ok   = run_valid && run_value && (len_eff >= MIN_RUN);
        line_cand = '{row: row_q, run: '{start: x_q, len: len_eff}};
        row_full  = (row_q == IMAGE_H - ROW_W'(1));
    end

    // Position, row, sticky error and line result next-state.
    always_comb begin
        x_d        = x_q;
        row_d      = row_q;
        line_d     = line_q;
        geom_err_d = geom_err_q | overflow | (line_done & row_full);
        if (run_valid) begin
            x_d = x_q + X_W'(len_eff);
        end
        if (line_done) begin
            x_d    = '0;
            line_d = line_merged.run;
            if (!row_full) begin
                row_d = row_q + ROW_W'(1);
            end
        end
        // A frame boundary wins over everything, even a coincident line end.
        if (frame_done) begin
            x_d        = '0;
            row_d      = '0;
            geom_err_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q        <= '0;
            row_q      <= '0;
            geom_err_q <= 1'b0;
            line_q     <= '0;
        end else begin
            x_q        <= x_d;
            row_q      <= row_d;
            geom_err_q <= geom_err_d;
            line_q     <= line_d;
        end
    end

    // Line best: cleared at every line or frame boundary.
    rle_best_tracker u_line_best (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .clr_i    (line_done | frame_done),
        .upd_i    (cand_ok),
        .cand_i   (line_cand),
        .merged_o (line_merged)
    );

    // FSM state register; both_q marks a line end coinciding with frame end.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_ACCUM;
            both_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            both_q  <= both_d;
        end
    end

    // FSM next state: frame output has priority over line output.
    always_comb begin
        state_d = ST_ACCUM;
        if (frame_done) begin
            state_d = ST_FRAME_OUT;
        end else if (line_done) begin
            state_d = ST_LINE_OUT;
        end
        both_d = frame_done & line_done;
    end

    // FSM outputs: one-cycle valid pulses.
    always_comb begin
        line_valid = (state_q == ST_LINE_OUT) | both_q;
`ifdef RLE_ANALYZER_FRAME_EN
        frame_valid = (state_q == ST_FRAME_OUT);
`else
        frame_valid = 1'b0;
`endif
    end

    assign line_start  = line_q.start;
    assign line_len    = line_q.len;
    assign line_center = run_center(line_q);
    assign geom_err    = geom_err_q;

`ifdef RLE_ANALYZER_FRAME_EN
    best_t frame_merged;
    best_t frame_q, frame_d;

    // Frame best: each finished line competes with the row it ended on.
    rle_best_tracker u_frame_best (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .clr_i    (frame_done),
        .upd_i    (line_done),
        .cand_i   (line_merged),
        .merged_o (frame_merged)
    );

    // Frame result capture, held until the next frame end.
    always_comb begin
        frame_d = frame_done ? frame_merged : frame_q;
    end

    // Frame result register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_row   = frame_q.row;
    assign frame_start = frame_q.run.start;
    assign frame_len   = frame_q.run.len;
`else
    // Row tag of the line best is only consumed by the frame tracker.
    logic unused_line_row;
    assign unused_line_row = ^line_merged.row;

    assign frame_row   = '0;
    assign frame_start = '0;
    assign frame_len   = '0;
`endif

endmodule

// File: tb/tb_rle_run_analyzer.sv
// tb_rle_run_analyzer: directed tests of the run analyzer with a 30-pixel,
// 4-line image and MIN_RUN=4. Frame expectations follow RLE_ANALYZER_FRAME_EN.
module tb_rle_run_analyzer;

`ifdef RLE_ANALYZER_FRAME_EN
    localparam bit FRAME_ON = 1'b1;
`else
    localparam bit FRAME_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        run_valid;
    logic        run_value;
    logic [9:0]  run_len;
    logic        line_end;
    logic        frame_end;
    logic        line_valid;
    logic [10:0] line_start;
    logic [9:0]  line_len;
    logic [10:0] line_center;
    logic        frame_valid;
    logic [9:0]  frame_row;
    logic [10:0] frame_start;
    logic [9:0]  frame_len;
    logic        geom_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    rle_run_analyzer #(
        .IMAGE_W (11'd30),
        .IMAGE_H (10'd4),
        .MIN_RUN (10'd4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .run_valid   (run_valid),
        .run_value   (run_value),
        .run_len     (run_len),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .line_valid  (line_valid),
        .line_start  (line_start),
        .line_len    (line_len),
        .line_center (line_center),
        .frame_valid (frame_valid),
        .frame_row   (frame_row),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .geom_err    (geom_err)
    );

    task automatic idle_inputs();
        run_valid = 1'b0; run_value = 1'b0; run_len = '0;
        line_end = 1'b0; frame_end = 1'b0;
    endtask

    // One run for one cycle; inputs return to idle #1 after the edge.
    task automatic drive(input logic v, input logic [9:0] l, input logic le, input logic fe);
        run_valid = 1'b1; run_value = v; run_len = l; line_end = le; frame_end = fe;
        @(posedge CLK); #1;
        idle_inputs();
    endtask

    task automatic frame_only();
        frame_end = 1'b1;
        @(posedge CLK); #1;
        idle_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic test_reset();
        RESET = 1'b1; idle_inputs();
        repeat (2) @(posedge CLK);
        #1; RESET = 1'b0;
        n_checks++; if (line_valid !== 1'b0) begin n_errors++; $display("FAIL reset_lv: got %b want 0", line_valid); end
        n_checks++; if (line_len !== 10'd0) begin n_errors++; $display("FAIL reset_len: got %0d want 0", line_len); end
        n_checks++; if (line_start !== 11'd0 || line_center !== 11'd0) begin n_errors++; $display("FAIL reset_pos: got start %0d center %0d want 0 0", line_start, line_center); end
        n_checks++; if (frame_valid !== 1'b0 || frame_len !== 10'd0 || frame_row !== 10'd0) begin n_errors++; $display("FAIL reset_frame: got fv %b len %0d row %0d want 0 0 0", frame_valid, frame_len, frame_row); end
        n_checks++; if (geom_err !== 1'b0) begin n_errors++; $display("FAIL reset_geom: got %b want 0", geom_err); end
        $display("txn reset done");
    endtask

    task automatic test_basic_line();
        drive(1'b0, 10'd10, 1'b0, 1'b0);
        drive(1'b1, 10'd5, 1'b0, 1'b0);
        drive(1'b0, 10'd3, 1'b0, 1'b0);
        n_checks++; if (line_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_lv: got %b want 0", line_valid); end
        drive(1'b1, 10'd12, 1'b1, 1'b0);
        $display("txn basic line: start=%0d len=%0d center=%0d", line_start, line_len, line_center);
        n_checks++; if (line_valid !== 1'b1) begin n_errors++; $display("FAIL basic_lv: got %b want 1", line_valid); end
        n_checks++; if (line_start !== 11'd18 || line_len !== 10'd12 || line_center !== 11'd24) begin n_errors++; $display("FAIL basic_result: got %0d/%0d/%0d want 18/12/24", line_start, line_len, line_center); end
        idle(1);
        n_checks++; if (line_valid !== 1'b0 || line_len !== 10'd12) begin n_errors++; $display("FAIL basic_hold: got lv %b len %0d want 0 12", line_valid, line_len); end
    endtask

    task automatic test_tie_and_min_run();
        drive(1'b1, 10'd6, 1'b0, 1'b0);
        drive(1'b0, 10'd2, 1'b0, 1'b0);
        drive(1'b1, 10'd6, 1'b1, 1'b0);
        $display("txn tie line: start=%0d len=%0d", line_start, line_len);
        n_checks++; if (line_valid !== 1'b1 || line_start !== 11'd0 || line_len !== 10'd6 || line_center !== 11'd3) begin n_errors++; $display("FAIL tie: got lv %b %0d/%0d/%0d want 1 0/6/3", line_valid, line_start, line_len, line_center); end
        drive(1'b1, 10'd3, 1'b1, 1'b0);
        $display("txn short run line: len=%0d", line_len);
        n_checks++; if (line_valid !== 1'b1 || line_start !== 11'd0 || line_len !== 10'd0 || line_center !== 11'd0) begin n_errors++; $display("FAIL min_run: got lv %b %0d/%0d/%0d want 1 0/0/0", line_valid, line_start, line_len, line_center); end
    endtask

    task automatic test_frame_best();
        // Closes the frame of rows 0..2 (lengths 12, 6, 0).
        frame_only();
        $display("txn frame end: fv=%b row=%0d len=%0d", frame_valid, frame_row, frame_len);
        n_checks++; if (frame_valid !== FRAME_ON || line_valid !== 1'b0) begin n_errors++; $display("FAIL frame1_valid: got fv %b lv %b want %b 0", frame_valid, line_valid, FRAME_ON); end
        n_checks++; if (frame_row !== 10'd0 || frame_len !== (FRAME_ON ? 10'd12 : 10'd0) || frame_start !== (FRAME_ON ? 11'd18 : 11'd0)) begin n_errors++; $display("FAIL frame1_result: got row %0d start %0d len %0d", frame_row, frame_start, frame_len); end
        drive(1'b1, 10'd5, 1'b1, 1'b0);
        drive(1'b0, 10'd3, 1'b0, 1'b0);
        drive(1'b1, 10'd9, 1'b1, 1'b0);
        drive(1'b1, 10'd9, 1'b1, 1'b0);
        idle(1);
        n_checks++; if (frame_valid !== 1'b0 || frame_len !== (FRAME_ON ? 10'd12 : 10'd0)) begin n_errors++; $display("FAIL frame_hold: got fv %b len %0d", frame_valid, frame_len); end
        frame_only();
        $display("txn frame end: fv=%b row=%0d start=%0d len=%0d", frame_valid, frame_row, frame_start, frame_len);
        n_checks++; if (frame_valid !== FRAME_ON) begin n_errors++; $display("FAIL frame2_valid: got %b want %b", frame_valid, FRAME_ON); end
        n_checks++; if (frame_row !== (FRAME_ON ? 10'd1 : 10'd0) || frame_len !== (FRAME_ON ? 10'd9 : 10'd0) || frame_start !== (FRAME_ON ? 11'd3 : 11'd0)) begin n_errors++; $display("FAIL frame2_result: got row %0d start %0d len %0d", frame_row, frame_start, frame_len); end
        n_checks++; if (geom_err !== 1'b0) begin n_errors++; $display("FAIL frame2_geom: got %b want 0", geom_err); end
    endtask

    task automatic test_overflow();
        drive(1'b0, 10'd20, 1'b0, 1'b0);
        drive(1'b1, 10'd15, 1'b1, 1'b0);
        $display("txn overflow line: start=%0d len=%0d geom=%b", line_start, line_len, geom_err);
        n_checks++; if (line_start !== 11'd20 || line_len !== 10'd10 || line_center !== 11'd25) begin n_errors++; $display("FAIL ovf_clamp: got %0d/%0d/%0d want 20/10/25", line_start, line_len, line_center); end
        n_checks++; if (geom_err !== 1'b1) begin n_errors++; $display("FAIL ovf_geom: got %b want 1", geom_err); end
        drive(1'b0, 10'd25, 1'b0, 1'b0);
        drive(1'b1, 10'd10, 1'b0, 1'b0);
        drive(1'b1, 10'd8, 1'b1, 1'b0);
        $display("txn overflow line: start=%0d len=%0d", line_start, line_len);
        n_checks++; if (line_start !== 11'd25 || line_len !== 10'd5 || line_center !== 11'd27) begin n_errors++; $display("FAIL ovf_after: got %0d/%0d/%0d want 25/5/27", line_start, line_len, line_center); end
        idle(2);
        n_checks++; if (geom_err !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", geom_err); end
        frame_only();
        $display("txn frame end: row=%0d start=%0d len=%0d geom=%b", frame_row, frame_start, frame_len, geom_err);
        n_checks++; if (geom_err !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", geom_err); end
        n_checks++; if (frame_row !== 10'd0 || frame_len !== (FRAME_ON ? 10'd10 : 10'd0) || frame_start !== (FRAME_ON ? 11'd20 : 11'd0)) begin n_errors++; $display("FAIL ovf_frame: got row %0d start %0d len %0d", frame_row, frame_start, frame_len); end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 10'd4, 1'b0, 1'b0);
        drive(1'b1, 10'd20, 1'b1, 1'b1);
        $display("txn line+frame end: lv=%b fv=%b len=%0d flen=%0d", line_valid, frame_valid, line_len, frame_len);
        n_checks++; if (line_valid !== 1'b1 || frame_valid !== FRAME_ON) begin n_errors++; $display("FAIL simul_valid: got lv %b fv %b want 1 %b", line_valid, frame_valid, FRAME_ON); end
        n_checks++; if (line_start !== 11'd4 || line_len !== 10'd20 || line_center !== 11'd14) begin n_errors++; $display("FAIL simul_line: got %0d/%0d/%0d want 4/20/14", line_start, line_len, line_center); end
        n_checks++; if (frame_row !== 10'd0 || frame_len !== (FRAME_ON ? 10'd20 : 10'd0) || frame_start !== (FRAME_ON ? 11'd4 : 11'd0)) begin n_errors++; $display("FAIL simul_frame: got row %0d start %0d len %0d", frame_row, frame_start, frame_len); end
        idle(1);
        n_checks++; if (line_valid !== 1'b0 || frame_valid !== 1'b0) begin n_errors++; $display("FAIL simul_pulse: got lv %b fv %b want 0 0", line_valid, frame_valid); end
    endtask

    task automatic test_frame_mid_line();
        drive(1'b1, 10'd12, 1'b0, 1'b0);
        frame_only();
        $display("txn mid-line frame end: lv=%b fv=%b flen=%0d", line_valid, frame_valid, frame_len);
        n_checks++; if (line_valid !== 1'b0 || frame_valid !== FRAME_ON || frame_len !== 10'd0) begin n_errors++; $display("FAIL midline_frame: got lv %b fv %b flen %0d", line_valid, frame_valid, frame_len); end
        drive(1'b1, 10'd7, 1'b1, 1'b0);
        $display("txn line after discard: start=%0d len=%0d", line_start, line_len);
        n_checks++; if (line_start !== 11'd0 || line_len !== 10'd7 || line_center !== 11'd3) begin n_errors++; $display("FAIL midline_next: got %0d/%0d/%0d want 0/7/3", line_start, line_len, line_center); end
    endtask

    task automatic test_row_overflow();
        frame_only();
        for (int i = 0; i < 3; i++) drive(1'b1, 10'd4, 1'b1, 1'b0);
        n_checks++; if (geom_err !== 1'b0) begin n_errors++; $display("FAIL row_early: got %b want 0", geom_err); end
        drive(1'b1, 10'd5, 1'b1, 1'b0);
        $display("txn last row end: geom=%b", geom_err);
        n_checks++; if (geom_err !== 1'b1) begin n_errors++; $display("FAIL row_ovf: got %b want 1", geom_err); end
        drive(1'b1, 10'd6, 1'b1, 1'b0);
        frame_only();
        $display("txn frame end: row=%0d len=%0d", frame_row, frame_len);
        n_checks++; if (frame_row !== (FRAME_ON ? 10'd3 : 10'd0) || frame_len !== (FRAME_ON ? 10'd6 : 10'd0)) begin n_errors++; $display("FAIL row_hold: got row %0d len %0d", frame_row, frame_len); end
    endtask

    task automatic test_reset_mid_line();
        drive(1'b1, 10'd15, 1'b0, 1'b0);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        $display("txn reset mid-line: lv=%b fv=%b len=%0d", line_valid, frame_valid, line_len);
        n_checks++; if (line_valid !== 1'b0 || frame_valid !== 1'b0 || line_len !== 10'd0 || geom_err !== 1'b0) begin n_errors++; $display("FAIL rst_mid: got lv %b fv %b len %0d geom %b", line_valid, frame_valid, line_len, geom_err); end
        drive(1'b0, 10'd2, 1'b0, 1'b0);
        drive(1'b1, 10'd5, 1'b1, 1'b0);
        n_checks++; if (line_start !== 11'd2 || line_len !== 10'd5 || line_center !== 11'd4) begin n_errors++; $display("FAIL rst_next: got %0d/%0d/%0d want 2/5/4", line_start, line_len, line_center); end
        frame_only();
        n_checks++; if (frame_row !== 10'd0 || frame_len !== (FRAME_ON ? 10'd5 : 10'd0) || frame_start !== (FRAME_ON ? 11'd2 : 11'd0)) begin n_errors++; $display("FAIL rst_frame: got row %0d start %0d len %0d", frame_row, frame_start, frame_len); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] lens [3];
        lens[0] = 10'd4; lens[1] = 10'd6; lens[2] = 10'd5;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, lens[i], 1'b1, 1'b0);
            $display("txn back-to-back line %0d: lv=%b len=%0d", i, line_valid, line_len);
            n_checks++; if (line_valid !== 1'b1 || line_len !== lens[i] || line_start !== 11'd0) begin n_errors++; $display("FAIL b2b_%0d: got lv %b len %0d start %0d want 1 %0d 0", i, line_valid, line_len, line_start, lens[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_line();
        test_tie_and_min_run();
        test_frame_best();
        test_overflow();
        test_simultaneous();
        test_frame_mid_line();
        test_row_overflow();
        test_reset_mid_line();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rle_run_analyzer.md
# rle_run_analyzer

Streaming consumer of binary run-length codes for the rover vision pipeline. It sits directly downstream of the RLE encoder and accepts one run per cycle. Per line, it reports the longest run of foreground (1) pixels: start x, length and centre. Per frame, it reports the line holding the widest such run, which the navigation logic uses as the target bearing.

## Interface
- IMAGE_W, 11'd640, pixels per line; the sum of run lengths in a line must not exceed it
- IMAGE_H, 10'd480, lines per frame
- MIN_RUN, 10'd4, foreground runs shorter than this are ignored
- CLK  in  1  clock; every register updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- run_valid  in  1  one run presented this cycle
- run_value  in  1  pixel value of the run (1 = foreground)
- run_len  in  10  run length in pixels
- line_end  in  1  qualified by run_valid; marks the last run of the line
- frame_end  in  1  single-cycle pulse; not qualified by run_valid
- line_valid  out  1  one-cycle pulse; line result is valid
- line_start  out  11  x of the best run in the line
- line_len  out  10  length of the best run (0 = none)
- line_center  out  11  line_start + (line_len >> 1)
- frame_valid  out  1  one-cycle pulse; frame result is valid
- frame_row  out  10  row index of the widest run in the frame
- frame_start / frame_len  out  11 / 10  best run of the frame
- geom_err  out  1  sticky: line overflow or row overflow; cleared by frame_end or RESET

## Operation
- The block has no backpressure and is always ready; at most one run arrives per cycle.
- x position (11 b, starts at 0): each accepted run uses start = x, then x <= x + run_len.
- Candidate run: run_value=1 and run_len >= MIN_RUN. It replaces the line best only if its length is strictly greater, so on a tie the leftmost run wins.
- run_len=0: contributes nothing to x or to the best run. If line_end is set with it, the line still ends.
- Line overflow: if x + run_len > IMAGE_W, the run is clamped to IMAGE_W - x and geom_err is set. Further runs before line_end have length 0.
- line_end: the line result (including the terminating run) is registered to the outputs. Then x <= 0, the line best is cleared and row <= row + 1.
- Row counter: 10 b. At IMAGE_H-1 a further line_end holds the counter and sets geom_err.
- Frame best: at each line_end, if the line best length is strictly greater than the frame best length, then frame best <= {row, start, len}.
- frame_end: the frame result is registered. Then row, x, the line best and the frame best clear, and geom_err clears.
- Simultaneous line_end (with run_valid) and frame_end: the line completes first and takes part in the frame comparison. Both valids pulse on the same cycle.
- frame_end in the middle of a line: the partial line is discarded, with no line_valid for it.
- Reset values: all outputs 0; x=0, row=0, bests cleared. RESET mid-line discards all state with no output pulses.

## Timing
- Latency is 1 cycle: line_end in cycle N gives line_valid in N+1, and frame_end in N gives frame_valid in N+1.
- line_start, line_len and line_center hold until the next line_valid. The frame outputs hold until the next frame_valid.
- Throughput: one run per cycle, and back-to-back line_end every cycle is supported.
- Control FSM: ACCUM, then LINE_OUT on line_end, then ACCUM. FRAME_OUT is entered on frame_end and has priority over LINE_OUT; it returns to ACCUM. The output states last one cycle and still accept the next run in that cycle.

## Configuration
- RLE_ANALYZER_FRAME_EN defined: the frame best, frame outputs and frame_valid are present as described.
- Not defined: no frame-best logic. frame_valid, frame_row, frame_start and frame_len are tied to 0. frame_end still clears row, x, the line best and geom_err.

## Structure
- Shared package rle_pkg holds:
  - X_W=11, LEN_W=10, ROW_W=10
  - typedef run_t {start[X_W], len[LEN_W]}
  - typedef best_t {row[ROW_W], run_t}
  - the analyzer FSM state enum
- One sub-module, rle_best_tracker: a strictly-greater compare-and-hold register with a clear input. It is instantiated once for the line best and, under the macro, once for the frame best.

## Test plan
- Line of runs (0,10),(1,5),(0,3),(1,12+line_end), IMAGE_W=30: line_valid one cycle later with start=18, len=12, center=24.
- Tie: (1,6),(0,2),(1,6+line_end): start=0, len=6. Run (1,3) with MIN_RUN=4: len=0, start=0, center=0.
- Three lines with best lengths 5, 9, 9, then frame_end: frame_row=1, frame_len=9; geom_err=0.
- Overflow: (1,25),(1,10+line_end) with IMAGE_W=30: second run clamped to 5, geom_err=1 until frame_end.
- frame_end in the same cycle as a line_end run of (1,20): line_valid and frame_valid in the same cycle, and the frame result includes len=20.
- RESET asserted mid-line after (1,15): no pulses. The next line reports only runs after reset, with row=0.
